m_demux14_deser: RTL and testbench
==================================

// Module: m_demux14_deser
// PURPOSE
//   Registered 1-to-NR_LANE demultiplexer/deserializer, the receive-side inverse of the 4:1 key mux.
//   - Accepts one DATA_LEN beat per handshake and steers it into a lane register.
//   - Lane chosen by an internal round-robin counter or by an explicit sel key.
//   - When every lane holds a beat, presents the assembled word downstream with a valid/ready handshake.
// PARAMETERS
//   NR_LANE   4  number of output lanes (>=2)
//   SEL_LEN   2  lane key width, 2**SEL_LEN >= NR_LANE
//   DATA_LEN  1  bits per lane/beat
// PORTS
//   clk        in   1                  single clock; all state updates on posedge
//   rst        in   1                  synchronous, active-high reset
//   mode       in   1                  0 = round-robin lane order, 1 = addressed by sel
//   sel        in   SEL_LEN            target lane in addressed mode; ignored in mode 0
//   in_valid   in   1                  upstream beat present
//   in_data    in   DATA_LEN           beat payload
//   in_ready   out  1                  block can accept a beat this cycle
//   out        out  NR_LANE*DATA_LEN   lane n at [DATA_LEN*(n+1)-1 : DATA_LEN*n]
//   out_valid  out  1                  assembled word valid
//   out_ready  in   1                  downstream takes word
// BEHAVIOUR
//   - State: COLLECT, FULL. Registers: lane regs, fill mask[NR_LANE], cnt[SEL_LEN], latched mode_q.
//   - Reset (rst high at posedge):
//     - state=COLLECT, out=0, out_valid=0, mask=0, cnt=0, mode_q=0.
//     - in_ready=0 while rst is high; any partial frame is discarded, including reset mid-frame or in FULL.
//   - Beat acceptance: accept = in_valid & in_ready.
//   - COLLECT:
//     - in_ready=1.
//     - Mode latch: if mask==0, mode is sampled into mode_q on the accepted beat. Mode changes mid-frame are ignored until the next frame.
//     - Lane select: lane = mode_q ? sel : cnt. The first beat uses the live mode.
//     - On accept: lane reg <= in_data and mask[lane] <= 1.
//     - Counter: cnt increments only in round-robin mode and wraps to 0 after NR_LANE-1.
//     - Invalid key: addressed sel >= NR_LANE has its beat accepted and dropped; mask unchanged.
//     - Duplicate lane: addressed write to an already-filled lane overwrites data; mask unchanged.
//     - Completion: when the accept makes mask all ones, next cycle state=FULL and out_valid=1.
//       Latency is one cycle from the last beat to out_valid.
//   - FULL:
//     - out_valid=1; out is stable.
//     - in_ready=0 (see CONFIGURATION).
//     - On out_ready: next cycle state=COLLECT, out_valid=0, mask=0, cnt=0. out keeps its last value.
//   - in_valid without in_ready: no state change; upstream must hold its data.
//   - No combinational path from in_* to out/out_valid. in_ready depends only on state, rst and (optionally) out_ready.
// CONFIGURATION
//   DEMUX_FLOW_THROUGH_EN
//   - Defined:
//     - In FULL, in_ready = out_ready.
//     - A beat accepted in the same cycle as the drain becomes beat 0 of the new frame: mask, cnt and mode_q restart from it.
//     - Back-to-back frames therefore run with no bubble: NR_LANE beats per word.
//   - Undefined:
//     - In FULL, in_ready=0.
//     - One idle input cycle per frame: NR_LANE+1 cycles per word.
// TESTING
//   - Reset: hold rst 2 cycles with in_valid=1 -> in_ready=0, out=0, out_valid=0. After release, in_ready=1.
//   - Round robin, defaults: beats 1,0,1,1 on consecutive cycles -> next cycle out=4'b1101, out_valid=1.
//     Hold out_ready=0 5 cycles -> out stable, in_ready=0.
//   - Addressed: mode=1, (sel,data) = (3,1),(1,1),(1,0),(0,1),(2,0).
//     -> lane 1 overwritten to 0; out_valid after the 5th beat with out=4'b1001.
//     -> sel change on a stalled beat has no effect.
//   - Mode latch: first beat mode=0, then mode=1 with sel=3 for beats 2-4 -> lanes 1,2,3 fill in order.
//     out_valid after exactly 4 beats.
//   - Reset mid-frame: 2 beats accepted, rst pulse, then 4 beats 0,0,0,1 -> out=4'b1000. Stale lanes never appear.
//   - Throughput: continuous in_valid, out_ready=1 for 3 frames.
//     -> 4 cycles/word with DEMUX_FLOW_THROUGH_EN defined, 5 cycles/word without.

Source files
------------

// File: rtl/m_demux14_deser.sv
// Registered 1-to-NR_LANE deserializer: steers beats into lane registers (round-robin or by sel key)
// and presents the assembled word with valid/ready. Optional macro DEMUX_FLOW_THROUGH_EN allows a beat to be accepted while the full word drains.
module m_demux14_deser #(
  parameter int NR_LANE  = 4,
  parameter int SEL_LEN  = 2,
  parameter int DATA_LEN = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mode,
  input  logic [SEL_LEN-1:0]           sel,
  input  logic                         in_valid,
  input  logic [DATA_LEN-1:0]          in_data,
  output logic                         in_ready,
  output logic [NR_LANE*DATA_LEN-1:0]  out,
  output logic                         out_valid,
  input  logic                         out_ready
);

  typedef enum logic {COLLECT, FULL} state_e;

  localparam logic [SEL_LEN-1:0] CNT_LAST  = SEL_LEN'(NR_LANE - 1);
  localparam logic [SEL_LEN:0]   NR_LANE_W = (SEL_LEN + 1)'(NR_LANE);

  state_e                      state_q, state_d;
  logic [NR_LANE-1:0]          mask_q, mask_d;
  logic [SEL_LEN-1:0]          cnt_q, cnt_d;
  logic                        mode_q, mode_d;
  logic [NR_LANE*DATA_LEN-1:0] lane_q, lane_d;
  logic [NR_LANE*DATA_LEN-1:0] out_q, out_d;

  logic               accept, drain, frame_start, eff_mode, key_ok;
  logic [NR_LANE-1:0] base_mask;
  logic [SEL_LEN-1:0] base_cnt, lane;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: lane storage is cleared on reset too, so no beat from an aborted frame can ever resurface on out.
      state_q <= COLLECT;
      mask_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      lane_q  <= '0;
      out_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the pre-edge values computed in always_comb.
      state_q <= state_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      lane_q  <= lane_d;
      out_q   <= out_d;
    end
  end

  // Next-state logic. A beat taken while FULL drains starts a fresh frame.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred on any path.
    state_d = state_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    lane_d  = lane_q;
    out_d   = out_q;

    accept      = in_valid & in_ready;
    drain       = (state_q == FULL) & out_ready;
    frame_start = (state_q == FULL) || (mask_q == '0);
    base_mask   = (state_q == FULL) ? '0 : mask_q;
    base_cnt    = (state_q == FULL) ? '0 : cnt_q;
    eff_mode    = frame_start ? mode : mode_q;
    lane        = eff_mode ? sel : base_cnt;
    key_ok      = {1'b0, lane} < NR_LANE_W;

    if (drain) begin
      state_d = COLLECT;
      mask_d  = '0;
      cnt_d   = '0;
    end

    if (accept) begin
      if (frame_start) mode_d = mode;
      mask_d = base_mask;
      cnt_d  = base_cnt;
      if (!eff_mode) cnt_d = (base_cnt == CNT_LAST) ? '0 : base_cnt + 1'b1;
      for (int n = 0; n < NR_LANE; n++) begin
        if (key_ok && (lane == SEL_LEN'(n))) begin
          lane_d[n*DATA_LEN +: DATA_LEN] = in_data;
          mask_d[n]                      = 1'b1;
        end
      end
      if (&mask_d) begin
        state_d = FULL;
        out_d   = lane_d;
      end
    end
  end

  // Outputs: in_ready from state/rst (and out_ready when flowing through), word from registers only.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = (state_q == FULL);
    out       = out_q;
    if (!rst) begin
      case (state_q)
        COLLECT: in_ready = 1'b1;
        FULL: begin
`ifdef DEMUX_FLOW_THROUGH_EN
          in_ready = out_ready;
`else
          in_ready = 1'b0;
`endif
        end
        default: in_ready = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_m_demux14_deser.sv
// Self-checking bench for m_demux14_deser: directed scenarios plus random traffic against a lane/array model.
module tb_m_demux14_deser;

  logic       clk = 1'b0;
  logic       rst, mode, in_valid, in_data, out_ready;
  logic [1:0] sel;
  logic       in_ready, out_valid;
  logic [3:0] out;

  int checks   = 0;
  int failures = 0;

  m_demux14_deser dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

`ifdef DEMUX_FLOW_THROUGH_EN
  localparam bit FT     = 1'b1;
  localparam int PERIOD = 4;
`else
  localparam bit FT     = 1'b0;
  localparam int PERIOD = 5;
`endif

  // Behavioural model: a word is "full" once each of the four lanes has been written this frame.
  bit m_full   = 1'b0;
  bit m_mode   = 1'b0;
  int m_cnt    = 0;
  bit m_filled [4];
  bit m_lane   [4];
  int m_out    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_ready(input bit r, input bit ordy);
    if (r) return 1'b0;
    if (!m_full) return 1'b1;
    return FT ? ordy : 1'b0;
  endfunction

  function automatic bit any_filled();
    for (int i = 0; i < 4; i++) if (m_filled[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step(input bit r, input bit acc, input bit d, input bit m, input int s, input bit ordy);
    bit new_frame;
    int ln;
    bit all;
    if (r) begin
      m_full = 0; m_mode = 0; m_cnt = 0; m_out = 0;
      for (int i = 0; i < 4; i++) begin m_filled[i] = 0; m_lane[i] = 0; end
      return;
    end
    new_frame = m_full || !any_filled();
    if (m_full && ordy) begin
      m_full = 0; m_cnt = 0;
      for (int i = 0; i < 4; i++) m_filled[i] = 0;
    end
    if (acc) begin
      if (new_frame) m_mode = m;
      ln = m_mode ? s : m_cnt;
      if (!m_mode) m_cnt = (m_cnt + 1) % 4;
      if (ln < 4) begin m_lane[ln] = d; m_filled[ln] = 1; end
      all = 1;
      for (int i = 0; i < 4; i++) all &= m_filled[i];
      if (all) begin
        m_full = 1;
        m_out  = 0;
        for (int i = 0; i < 4; i++) m_out += int'(m_lane[i]) << i;
      end
    end
  endtask

  // One clock cycle: drive at the falling edge, check in_ready before the rising edge, check outputs after it.
  task automatic cyc(input bit r, input bit v, input bit d, input bit m, input int s, input bit ordy);
    bit er;
    rst = r; in_valid = v; in_data = d; mode = m; sel = 2'(s); out_ready = ordy;
    #1;
    er = model_ready(r, ordy);
    check("in_ready", {31'b0, in_ready}, {31'b0, er});
    model_step(r, v & er, d, m, s, ordy);
    @(posedge clk); #1;
    check("out_valid", {31'b0, out_valid}, {31'b0, m_full});
    check("out", {28'b0, out}, m_out);
    @(negedge clk);
  endtask

  int ov_hits [$];

  initial begin
    // Reset held two cycles with in_valid asserted.
    cyc(1, 1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0);
    check("rst_out", {28'b0, out}, 0);
    check("rst_ovalid", {31'b0, out_valid}, 0);

    // Round robin 1,0,1,1 then stall downstream five cycles.
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);
    check("rr_word", {28'b0, out}, 32'hD);
    check("rr_valid", {31'b0, out_valid}, 1);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, i % 4, 0);
    check("rr_hold", {28'b0, out}, 32'hD);
    cyc(0, 0, 0, 0, 0, 1);
    check("rr_drained", {31'b0, out_valid}, 0);

    // Addressed with overwrite of lane 1, then a stalled beat with changing sel.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 1, 3, 0);
    cyc(0, 1, 1, 1, 1, 0);
    cyc(0, 1, 0, 1, 1, 0);
    cyc(0, 1, 1, 1, 0, 0);
    check("addr_not_yet", {31'b0, out_valid}, 0);
    cyc(0, 1, 0, 1, 2, 0);
    check("addr_word", {28'b0, out}, 32'h9);
    for (int s = 0; s < 4; s++) cyc(0, 1, 1, 1, s, 0);
    check("addr_stall", {28'b0, out}, 32'h9);

    // Addressed invalid key is impossible with 2-bit sel and 4 lanes; mode latch next.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 1, 3, 0);
    cyc(0, 1, 1, 1, 3, 0);
    cyc(0, 1, 0, 1, 3, 0);
    check("latch_word", {28'b0, out}, 32'h6);
    check("latch_valid", {31'b0, out_valid}, 1);

    // Reset mid-frame discards the partial frame.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);
    check("midrst_word", {28'b0, out}, 32'h8);

    // Throughput: continuous traffic, downstream always ready.
    cyc(1, 0, 0, 0, 0, 1);
    for (int c = 0; c < 3 * PERIOD + 2; c++) begin
      cyc(0, 1, 1'($urandom), 0, 0, 1);
      if (out_valid) ov_hits.push_back(c);
    end
    check("tp_frames", ov_hits.size(), 3);
    for (int i = 1; i < ov_hits.size(); i++)
      check("tp_period", ov_hits[i] - ov_hits[i-1], PERIOD);

    // Random traffic, mixed modes, occasional reset.
    cyc(1, 0, 0, 0, 0, 0);
    for (int c = 0; c < 400; c++)
      cyc(($urandom_range(0, 39) == 0), 1'($urandom), 1'($urandom),
          ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)), 1'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
